// File: rtl/dispatch_queue.sv
// dispatch_queue: in-order dispatch buffer between decode and the ALU / LSQ /
// branch units. A circular buffer of {FUType, payload} entries; only the head
// entry is offered, to the unit selected by its FUType. A head entry with
// FUType 3'b000, or any code not assigned to a unit, is discarded with a
// one-cycle DropPulse so that it cannot stall the queue.
// Optional feature: DISPATCH_BYPASS_EN. When it is defined, an instruction
// arriving at an empty queue is offered in the same cycle and is written into
// the queue only if its unit does not take it.
module dispatch_queue #(
  parameter int DEPTH = 4,
  parameter int PW    = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     Flush,
  input  logic                     InValid,
  output logic                     InReady,
  input  logic [2:0]               InFUType,
  input  logic [PW-1:0]            InPayload,
  output logic                     AluValid,
  output logic                     LsqValid,
  output logic                     BraValid,
  input  logic                     AluReady,
  input  logic                     LsqReady,
  input  logic                     BraReady,
  output logic [PW-1:0]            OutPayload,
  output logic [$clog2(DEPTH):0]   Count,
  output logic                     Full,
  output logic                     Empty,
  output logic                     DropPulse
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  localparam logic [2:0] FU_ALU = 3'd1;
  localparam logic [2:0] FU_LSQ = 3'd2;
  localparam logic [2:0] FU_BRA = 3'd3;

  logic [PW+2:0] mem_q [DEPTH];
  logic [AW-1:0] head_q, head_d;
  logic [AW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;

  logic [2:0]    off_fu;
  logic [PW-1:0] off_pay;
  logic          off_vld;
  logic          sel_alu, sel_lsq, sel_bra, sel_drop;
  logic          take, push, pop;

  // Select the offered entry, decode its unit, and work out push/pop.
  always_comb begin
    Full    = (count_q == CW'(DEPTH));
    Empty   = (count_q == '0);
    InReady = !Full;
    Count   = count_q;

    off_fu  = mem_q[head_q][PW+2:PW];
    off_pay = mem_q[head_q][PW-1:0];
    off_vld = !Empty;
`ifdef DISPATCH_BYPASS_EN
    if (Empty) begin
      off_fu  = InFUType;
      off_pay = InPayload;
      off_vld = InValid && !Flush;
    end
`endif

    sel_alu  = (off_fu == FU_ALU);
    sel_lsq  = (off_fu == FU_LSQ);
    sel_bra  = (off_fu == FU_BRA);
    sel_drop = !(sel_alu || sel_lsq || sel_bra);

    AluValid   = off_vld && sel_alu && !rst;
    LsqValid   = off_vld && sel_lsq && !rst;
    BraValid   = off_vld && sel_bra && !rst;
    // A flush already discards the head, so no separate drop is reported then.
    DropPulse  = off_vld && sel_drop && !Flush && !rst;
    OutPayload = off_pay;

    take = (AluValid && AluReady) || (LsqValid && LsqReady) ||
           (BraValid && BraReady) || DropPulse;
    // With an empty queue a take can only be the bypassed instruction, which
    // then never enters storage.
    pop  = take && !Empty;
    push = InValid && !Full && !(Empty && take);

    head_d  = head_q + AW'(pop);
    tail_d  = tail_q + AW'(push);
    count_d = count_q + CW'(push) - CW'(pop);
    if (Flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end
  end

  // Pointer and occupancy registers; reset overrides everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Entry storage; contents are only meaningful below Count, so no reset.
  always_ff @(posedge clk) begin
    if (push && !Flush) begin
      mem_q[tail_q] <= {InFUType, InPayload};
    end
  end

endmodule

// File: doc/dispatch_queue.md
DISPATCH_QUEUE -- requirements
Module: dispatch_queue

Interface
REQ-001 The module SHALL have parameter DEPTH, default 4, meaning queue entries; legal values are powers of two, 2..16.
REQ-002 The module SHALL have parameter PW, default 64, meaning payload width in bits (decoded control fields, PC, register tags).
REQ-003 The module SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 The module SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 The module SHALL have port Flush  input  1  synchronous discard of all queued entries.
REQ-006 The module SHALL have port InValid  input  1  decoder presents an instruction.
REQ-007 The module SHALL have port InReady  output  1  queue accepts; transfer occurs when InValid & InReady.
REQ-008 The module SHALL have port InFUType  input  3  function-unit code from decoder (FU_ALU / FU_LSQ / FU_BRA of defines.vh; 3'b000 = none).
REQ-009 The module SHALL have port InPayload  input  PW  decoded instruction bundle.
REQ-010 The module SHALL have ports AluValid / LsqValid / BraValid  output  1 each  head entry offered to that unit.
REQ-011 The module SHALL have ports AluReady / LsqReady / BraReady  input  1 each  unit can accept this cycle.
REQ-012 The module SHALL have port OutPayload  output  PW  head payload, shared by all three units.
REQ-013 The module SHALL have ports Count (output, $clog2(DEPTH)+1 bits, occupancy), Full (output, 1) and Empty (output, 1).
REQ-014 The module SHALL have port DropPulse  output  1  one-cycle pulse when a head entry with FUType 3'b000 is discarded.

Function
REQ-015 Storage SHALL be a circular buffer with head and tail pointers of $clog2(DEPTH) bits that wrap from DEPTH-1 to 0.
REQ-016 InReady SHALL equal !Full and SHALL NOT depend on the same-cycle pop.
REQ-017 A push SHALL write {InFUType, InPayload} at the tail, advance the tail and increment Count.
REQ-018 Dispatch SHALL be strictly in order; only the head entry SHALL be offered.
REQ-019 With Empty = 0, exactly one of AluValid/LsqValid/BraValid SHALL be high, selected by the head FUType; all three SHALL be low when Empty = 1 or the head FUType is 3'b000.
REQ-020 A pop SHALL occur when the selected Valid and its matching Ready are both high; a Ready on a non-selected unit SHALL have no effect.
REQ-021 A head entry with FUType 3'b000 SHALL be popped unconditionally in that cycle, with DropPulse asserted that cycle.
REQ-022 A simultaneous push and pop SHALL leave Count unchanged and move both pointers.
REQ-023 Flush SHALL take priority over push and pop in the same cycle: pointers return to 0, Count becomes 0, and the offered data is not consumed.
REQ-024 Full SHALL equal (Count == DEPTH), Empty SHALL equal (Count == 0), and Count SHALL never exceed DEPTH.
REQ-025 OutPayload SHALL be the head payload whenever Empty = 0 and is don't-care otherwise.
REQ-026 The latency from push to the first Valid SHALL be 1 cycle (registered path).

Reset
REQ-027 While rst is high, head, tail and Count SHALL be 0, Empty = 1, Full = 0, InReady = 1, all Valid outputs = 0 and DropPulse = 0.
REQ-028 rst asserted mid-operation SHALL discard all entries at the next edge, and rst SHALL override Flush, push and pop.
REQ-029 The entry storage array SHALL NOT require reset.

Configuration
REQ-030 Macro DISPATCH_BYPASS_EN, when defined, SHALL add a bypass path with the following behaviour when Empty = 1:
- the incoming instruction is offered in the same cycle (Valid = InValid for the unit selected by InFUType, OutPayload = InPayload);
- if the matching Ready is high, the instruction SHALL NOT be written to the queue;
- FUType 3'b000 arriving on the bypass SHALL be dropped with DropPulse in the same cycle;
- Flush in the same cycle SHALL suppress the bypass.
REQ-031 Without DISPATCH_BYPASS_EN, the Valid outputs SHALL depend only on registered state, and REQ-026 applies.

Verification
REQ-032 Reset sequence: after reset, push 4 ALU entries with AluReady = 0 -> Count = 4, Full = 1, InReady = 0; a 5th InValid is not accepted.
REQ-033 Mixed dispatch order: push LSQ, ALU, BRA (payloads 0x1, 0x2, 0x3) with all Ready held high -> the Valids fire in order LSQ, ALU, BRA with OutPayload 0x1, 0x2, 0x3 on consecutive cycles, starting 1 cycle after the first push (non-bypass build).
REQ-034 Head-of-line blocking: head is BRA with BraReady = 0, second entry is ALU with AluReady = 1 -> no pop occurs, AluValid = 0 and Count is held until BraReady = 1.
REQ-035 Wrap and concurrency: with DEPTH = 4, run 10 cycles of simultaneous push/pop at Count = 2 -> Count stays 2, the pointers wrap, and the payload sequence is preserved.
REQ-036 Drop and flush: push FUType 3'b000 -> DropPulse for one cycle and no Valid; then fill to 3, assert Flush together with InValid and a ready pop -> next cycle Count = 0, Empty = 1, nothing dispatched.
REQ-037 Bypass (DISPATCH_BYPASS_EN defined): from the empty queue, push ALU 0xAB with AluReady = 1 -> AluValid and OutPayload = 0xAB in the same cycle, and Count stays 0.
